seg7_scan_mux: RTL and testbench

Multiplexed, parametrised 7-segment display driver that succeeds the single-digit hex decoder. It holds an N-digit hex value and scans one digit at a time at a programmable refresh rate, driving shared segment lines plus one enable per digit. It adds per-digit decimal points, a blank mask, leading-zero suppression and tear-free updates. It sits between the system-side value producer and the board's common-anode or common-cathode display pins.

---
 rtl/seg7_pkg.sv | 25 ++
 rtl/seg7_hex_decoder.sv | 11 +
 rtl/seg7_scan_mux.sv | 187 ++++++++++++++++++
 tb/tb_seg7_scan_mux.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment bit positions, the hex glyph table
// and the pin polarity helper used by display drivers.
package seg7_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Logical glyphs for nibbles 0..F, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic pin_level(input logic on, input logic active_low);
    return on ^ active_low;
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to logical (active-high) 7-segment pattern.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/seg7_scan_mux.sv
// Multiplexed N-digit hex display driver with frame-synchronous updates,
// blanking, leading-zero suppression and anti-ghosting digit enables.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_suppress,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    frame_tick,
  output logic                    pending
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    wrap;
  logic                    pend_q, pend_d;
  logic [4*NUM_DIGITS-1:0] pval_q, pval_d, aval_q, aval_d;
  logic [NUM_DIGITS-1:0]   pdp_q, pdp_d, adp_q, adp_d;
  logic [NUM_DIGITS-1:0]   pbl_q, pbl_d, abl_q, abl_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   dig_q, dig_d;
  logic                    tick_q;

  logic [NUM_DIGITS-1:0]   lz_zero;
  logic [NUM_DIGITS-1:0]   sel_onehot;
  logic [3:0]              sel_nib;
  logic                    sel_dark, sel_dp;
  logic [6:0]              dec_seg;
  logic [6:0]              seg_log;
  logic                    dp_log;
  logic [NUM_DIGITS-1:0]   dig_log;

  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    wrap  = 1'b0;
    if (enable) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        if (idx_q == IDX_LAST) begin
          idx_d = '0;
          wrap  = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Active data only changes at a frame wrap so a frame never mixes values.
  always_comb begin
    pend_d = pend_q;
    pval_d = pval_q;
    pdp_d  = pdp_q;
    pbl_d  = pbl_q;
    aval_d = aval_q;
    adp_d  = adp_q;
    abl_d  = abl_q;
    if (wrap) begin
      pend_d = 1'b0;
      if (load) begin
        aval_d = value;
        adp_d  = dp_in;
        abl_d  = blank_in;
      end else if (pend_q) begin
        aval_d = pval_q;
        adp_d  = pdp_q;
        abl_d  = pbl_q;
      end
    end else if (load) begin
      pend_d = 1'b1;
      pval_d = value;
      pdp_d  = dp_in;
      pbl_d  = blank_in;
    end
  end

  always_comb begin
    logic run;
    run        = 1'b1;
    lz_zero    = '0;
    sel_onehot = '0;
    sel_nib    = 4'h0;
    sel_dark   = 1'b0;
    sel_dp     = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      run        = run & (aval_d[4*k +: 4] == 4'h0);
      lz_zero[k] = run;
    end
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_d == IDX_W'(k)) begin
        sel_onehot[k] = 1'b1;
        sel_nib       = aval_d[4*k +: 4];
        sel_dark      = abl_d[k] | (lz_suppress & (k > 0) & lz_zero[k]);
        sel_dp        = adp_d[k];
      end
    end
  end

  seg7_hex_decoder u_dec (
    .nibble_i (sel_nib),
    .seg_o    (dec_seg)
  );

  // Outputs are computed from next-state values so pins track cnt/idx on the same edge.
  always_comb begin
    seg_log = SEG_OFF;
    dp_log  = 1'b0;
    dig_log = '0;
    if (enable) begin
      if (!sel_dark) begin
        seg_log = dec_seg;
        dp_log  = sel_dp;
      end
      if (cnt_d != '0) begin
        dig_log = sel_onehot;
      end
    end
    for (int b = 0; b < 7; b++) begin
      seg_d[b] = pin_level(seg_log[b], SEG_ACTIVE_LOW);
    end
    dp_d = pin_level(dp_log, SEG_ACTIVE_LOW);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      dig_d[k] = pin_level(dig_log[k], DIG_ACTIVE_LOW);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      pend_q <= 1'b0;
      pval_q <= '0;
      pdp_q  <= '0;
      pbl_q  <= '0;
      aval_q <= '0;
      adp_q  <= '0;
      abl_q  <= '0;
      seg_q  <= {7{SEG_ACTIVE_LOW}};
      dp_q   <= SEG_ACTIVE_LOW;
      dig_q  <= {NUM_DIGITS{DIG_ACTIVE_LOW}};
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      pend_q <= pend_d;
      pval_q <= pval_d;
      pdp_q  <= pdp_d;
      pbl_q  <= pbl_d;
      aval_q <= aval_d;
      adp_q  <= adp_d;
      abl_q  <= abl_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      dig_q  <= dig_d;
      tick_q <= wrap;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign dig_en     = dig_q;
  assign frame_tick = tick_q;
  assign pending    = pend_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: an active-high and an active-low instance share
// stimulus and are compared every cycle against a scan-position model.
module tb_seg7_scan_mux;

  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int FRAME = N * DIV;
  localparam logic [6:0] TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        enable, load, lz_suppress;
  logic [15:0] value;
  logic [3:0]  dp_in, blank_in;
  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b, tick_a, tick_b, pend_a, pend_b;
  logic [3:0]  dig_a, dig_b;

  seg7_scan_mux #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)) u_dut_hi (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value), .dp_in(dp_in),
    .blank_in(blank_in), .lz_suppress(lz_suppress), .seg(seg_a), .dp(dp_a), .dig_en(dig_a),
    .frame_tick(tick_a), .pending(pend_a)
  );

  seg7_scan_mux #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) u_dut_lo (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value), .dp_in(dp_in),
    .blank_in(blank_in), .lz_suppress(lz_suppress), .seg(seg_b), .dp(dp_b), .dig_en(dig_b),
    .frame_tick(tick_b), .pending(pend_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: pos counts enabled cycles modulo one frame.
  int          pos;
  bit          m_pend;
  logic [15:0] p_val, a_val;
  logic [3:0]  p_dp, a_dp, p_bl, a_bl;
  logic [6:0]  e_seg;
  logic        e_dp, e_tick;
  logic [3:0]  e_dig;

  task automatic model_reset();
    pos = 0; m_pend = 0;
    p_val = 0; p_dp = 0; p_bl = 0;
    a_val = 0; a_dp = 0; a_bl = 0;
    e_seg = 0; e_dp = 0; e_dig = 0; e_tick = 0;
  endtask

  task automatic model_edge();
    bit bnd;
    int slot;
    bit dark;
    bnd = 0;
    if (enable) begin
      pos = (pos + 1) % FRAME;
      bnd = (pos == 0);
    end
    if (bnd) begin
      if (load) begin
        a_val = value; a_dp = dp_in; a_bl = blank_in;
      end else if (m_pend) begin
        a_val = p_val; a_dp = p_dp; a_bl = p_bl;
      end
      m_pend = 0;
    end else if (load) begin
      p_val = value; p_dp = dp_in; p_bl = blank_in;
      m_pend = 1;
    end
    e_tick = bnd;
    e_seg = 0; e_dp = 0; e_dig = 0;
    if (enable) begin
      slot = pos / DIV;
      dark = a_bl[slot] || (lz_suppress && slot > 0 && ((a_val >> (4 * slot)) == 16'h0));
      if (!dark) begin
        e_seg = TBL[(a_val >> (4 * slot)) & 16'hF];
        e_dp  = a_dp[slot];
      end
      if (pos % DIV != 0) e_dig = 4'(1 << slot);
    end
  endtask

  task automatic compare_all();
    logic [6:0] es_n;
    logic [3:0] ed_n;
    es_n = ~e_seg;
    ed_n = ~e_dig;
    check("seg", seg_a, e_seg);
    check("dp", dp_a, e_dp);
    check("dig_en", dig_a, e_dig);
    check("frame_tick", tick_a, e_tick);
    check("pending", pend_a, m_pend);
    check("seg_low", seg_b, es_n);
    check("dp_low", dp_b, !e_dp);
    check("dig_en_low", dig_b, ed_n);
    check("frame_tick_low", tick_b, e_tick);
    check("pending_low", pend_b, m_pend);
  endtask

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic load_word(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    load = 1'b1; value = v; dp_in = d; blank_in = b;
    cycle();
    load = 1'b0;
  endtask

  task automatic wait_tick(input string tag);
    bit seen;
    seen = 0;
    for (int i = 0; i < 3 * FRAME && !seen; i++) begin
      cycle();
      if (tick_a) seen = 1;
    end
    check(tag, seen, 1'b1);
  endtask

  logic [6:0] cap_seg [4];
  logic       cap_dp [4];
  logic [6:0] cap_seg_b [4];
  logic       cap_dp_b [4];
  logic [3:0] cap_dig_b [4];
  bit         saw_77;

  task automatic capture();
    for (int k = 0; k < N; k++) begin
      cap_seg[k] = 'x; cap_dp[k] = 'x; cap_seg_b[k] = 'x; cap_dp_b[k] = 'x; cap_dig_b[k] = 'x;
    end
    for (int i = 0; i < FRAME; i++) begin
      cycle();
      if (seg_a == 7'h77) saw_77 = 1;
      for (int k = 0; k < N; k++) begin
        if (dig_a[k]) begin
          cap_seg[k] = seg_a; cap_dp[k] = dp_a;
        end
        if (!dig_b[k]) begin
          cap_seg_b[k] = seg_b; cap_dp_b[k] = dp_b; cap_dig_b[k] = dig_b;
        end
      end
    end
  endtask

  // scoreboard for the first displayed frame
  logic [6:0] exp_q[$];
  logic [3:0] prev_dig;

  initial begin
    enable = 0; load = 0; value = 0; dp_in = 0; blank_in = 0; lz_suppress = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    check("rst_seg_low_pins", seg_b, 7'h7F);
    check("rst_dig_low_pins", dig_b, 4'hF);
    repeat (2) cycle();

    // Scan of 1234 with anti-ghost gap and 16-cycle frame tick
    rst_n = 1'b1;
    enable = 1'b1;
    load_word(16'h1234, 4'h0, 4'h0);
    wait_tick("first_tick");
    exp_q = {7'h66, 7'h4F, 7'h5B, 7'h06};
    prev_dig = 4'h0;
    for (int i = 1; i <= FRAME; i++) begin
      cycle();
      if (dig_a != 4'h0 && prev_dig == 4'h0 && exp_q.size() > 0) check("scan_seg", seg_a, exp_q.pop_front());
      prev_dig = dig_a;
      check("tick_period", tick_a, i == FRAME);
    end
    check("scan_queue_empty", exp_q.size(), 0);

    // Leading-zero suppression
    lz_suppress = 1'b1;
    load_word(16'h00A0, 4'h0, 4'h0);
    wait_tick("lz_tick");
    capture();
    check("lz_d3", cap_seg[3], 7'h00);
    check("lz_d2", cap_seg[2], 7'h00);
    check("lz_d1", cap_seg[1], 7'h77);
    check("lz_d0", cap_seg[0], 7'h3F);
    load_word(16'h0000, 4'h0, 4'h0);
    wait_tick("zero_tick");
    capture();
    check("zero_d3", cap_seg[3], 7'h00);
    check("zero_d1", cap_seg[1], 7'h00);
    check("zero_d0", cap_seg[0], 7'h3F);

    // Two loads mid-frame: last one wins, nothing torn
    lz_suppress = 1'b0;
    saw_77 = 0;
    repeat (3) cycle();
    load_word(16'hAAAA, 4'h0, 4'h0);
    load_word(16'h5555, 4'h0, 4'h0);
    check("pend_after_loads", pend_a, 1'b1);
    for (int i = 0; i < 3 * FRAME && !tick_a; i++) begin
      cycle();
      if (seg_a == 7'h77) saw_77 = 1;
    end
    capture();
    for (int k = 0; k < N; k++) check("five_digit", cap_seg[k], 7'h6D);
    check("no_77", saw_77, 1'b0);

    // Load on the exact boundary cycle
    for (int i = 0; i < 2 * FRAME && pos != FRAME - 1; i++) cycle();
    check("bnd_found", pos, FRAME - 1);
    load_word(16'h9876, 4'h0, 4'h0);
    check("bnd_pend", pend_a, 1'b0);
    check("bnd_tick", tick_a, 1'b1);
    check("bnd_d0", seg_a, 7'h7D);

    // Blank mask and decimal point seen through the active-low instance
    load_word(16'h1111, 4'b0001, 4'b0100);
    wait_tick("blank_tick");
    capture();
    check("blank_seg_low", cap_seg_b[2], 7'h7F);
    check("blank_dp_low", cap_dp_b[2], 1'b1);
    check("blank_dig_low", cap_dig_b[2], 4'b1011);
    check("dp0_low", cap_dp_b[0], 1'b0);
    check("d0_seg_low", cap_seg_b[0], 7'h79);

    // Enable low mid-slot, then reset
    repeat (2) cycle();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("frozen_dark", dig_a, 4'h0);
    end
    do_reset();
    check("post_rst_pend", pend_a, 1'b0);
    enable = 1'b1;
    for (int i = 1; i <= FRAME; i++) begin
      cycle();
      check("tick_after_rst", tick_a, i == FRAME);
    end

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      enable      = ($urandom_range(0, 9) != 0);
      load        = ($urandom_range(0, 7) == 0);
      value       = 16'($urandom) >> $urandom_range(0, 16);
      dp_in       = 4'($urandom);
      blank_in    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      lz_suppress = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 199) == 0) do_reset();
      else cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
